// File: rtl/bwdaux_alloc_ctrl_pkg.sv
// Shared definitions for the BWDAUX allocation controller: state encoding, default sizes and
// the round-robin pointer helper.
package bwdaux_alloc_ctrl_pkg;

  localparam int unsigned DefaultSwitchOutputs = 4;
  localparam int unsigned DefaultNumAux        = 3;

  localparam logic BWDAUX_IDLE   = 1'b0;
  localparam logic BWDAUX_LOCKED = 1'b1;

  typedef enum logic {
    StIdle   = BWDAUX_IDLE,
    StLocked = BWDAUX_LOCKED
  } bwdaux_state_e;

  // Pointer position following a released port, wrapping at n.
  function automatic int unsigned next_ptr(int unsigned idx, int unsigned n);
    return ((idx + 1) >= n) ? 0 : (idx + 1);
  endfunction

endpackage

// File: rtl/bwdaux_rr_arbiter.sv
// Round-robin one-hot picker: selects the first asserted request at or after ptr_i, wrapping.
module bwdaux_rr_arbiter #(
  parameter int unsigned N    = 4,
  parameter int unsigned PtrW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [PtrW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [PtrW-1:0] idx_o,
  output logic            valid_o
);

  always_comb begin
    int unsigned     cand;
    logic [PtrW-1:0] cand_idx;
    logic            found;
    gnt_o    = '0;
    idx_o    = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand     = (32'(ptr_i) + i) % N;
      cand_idx = PtrW'(cand);
      if (!found && req_i[cand_idx]) begin
        found           = 1'b1;
        gnt_o[cand_idx] = 1'b1;
        idx_o           = cand_idx;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/bwdaux_alloc_ctrl.sv
// Per-channel BWDAUX allocator: round-robin grant, packet-granular lock, registered outputs.
// Optional lock watchdog enabled by defining BWDAUX_TIMEOUT_EN.
module bwdaux_alloc_ctrl
  import bwdaux_alloc_ctrl_pkg::*;
#(
  parameter int unsigned SwitchOutputs = DefaultSwitchOutputs,
  parameter int unsigned NumAux        = DefaultNumAux,
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NumAux*SwitchOutputs-1:0]   req_i,
  input  logic [SwitchOutputs-1:0]          flit_valid_i,
  input  logic [SwitchOutputs-1:0]          flit_tail_i,
  input  logic [NumAux-1:0]                 aux_stall_i,
  output logic [NumAux*SwitchOutputs-1:0]   alloc_out_o,
  output logic [NumAux-1:0]                 aux_out_c_o,
  output logic [NumAux-1:0]                 timeout_err_o
);

  localparam int unsigned PtrW = (SwitchOutputs > 1) ? $clog2(SwitchOutputs) : 1;

  for (genvar a = 0; a < NumAux; a++) begin : g_chan
    bwdaux_state_e            state_q, state_d;
    logic [PtrW-1:0]          ptr_q, ptr_d;
    logic [PtrW-1:0]          gidx_q, gidx_d;
    logic [SwitchOutputs-1:0] grant_q, grant_d;
    logic                     aux_q, aux_d;
    logic [SwitchOutputs-1:0] req_a;
    logic [SwitchOutputs-1:0] arb_gnt;
    logic [PtrW-1:0]          arb_idx;
    logic                     any_req;
    logic                     accept;
    logic                     tail_accept;
    logic                     wd_fire;
    logic                     release_c;

    assign req_a = req_i[a*SwitchOutputs +: SwitchOutputs];

    bwdaux_rr_arbiter #(
      .N    (SwitchOutputs),
      .PtrW (PtrW)
    ) u_arb (
      .req_i   (req_a),
      .ptr_i   (ptr_q),
      .gnt_o   (arb_gnt),
      .idx_o   (arb_idx),
      .valid_o (any_req)
    );

    assign accept      = (state_q == StLocked) & flit_valid_i[gidx_q] & ~aux_stall_i[a];
    assign tail_accept = accept & flit_tail_i[gidx_q];

`ifdef BWDAUX_TIMEOUT_EN
    localparam int unsigned CntW = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q;

    assign wd_fire = (state_q == StLocked) & ~accept & (cnt_q == CntW'(TimeoutCycles - 1));

    // Idle holds the counter at zero so a fresh grant starts from a cleared count.
    always_comb begin
      cnt_d = cnt_q;
      if (state_q == StIdle || accept || wd_fire) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        cnt_q <= '0;
        err_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        err_q <= wd_fire;
      end
    end

    assign timeout_err_o[a] = err_q;
`else
    assign wd_fire          = 1'b0;
    assign timeout_err_o[a] = 1'b0;
`endif

    assign release_c = tail_accept | wd_fire;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        state_q <= StIdle;
      end else begin
        state_q <= state_d;
      end
    end

    always_comb begin
      state_d = state_q;
      unique case (state_q)
        StIdle:   if (any_req)   state_d = StLocked;
        StLocked: if (release_c) state_d = StIdle;
        default:                 state_d = StIdle;
      endcase
    end

    // Registered outputs are computed from the current grant, so release and re-grant
    // always fall on separate edges.
    always_comb begin
      grant_d = grant_q;
      gidx_d  = gidx_q;
      ptr_d   = ptr_q;
      if (state_q == StIdle) begin
        if (any_req) begin
          grant_d = arb_gnt;
          gidx_d  = arb_idx;
        end
      end else if (release_c) begin
        grant_d = '0;
        ptr_d   = PtrW'(next_ptr(32'(gidx_q), SwitchOutputs));
      end
      aux_d = (|(grant_q & flit_valid_i)) & ~aux_stall_i[a];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        grant_q <= '0;
        gidx_q  <= '0;
        ptr_q   <= '0;
        aux_q   <= 1'b0;
      end else begin
        grant_q <= grant_d;
        gidx_q  <= gidx_d;
        ptr_q   <= ptr_d;
        aux_q   <= aux_d;
      end
    end

    assign alloc_out_o[a*SwitchOutputs +: SwitchOutputs] = grant_q;
    assign aux_out_c_o[a]                                = aux_q;
  end

endmodule

// File: tb/tb_bwdaux_alloc_ctrl.sv
// Directed bench for bwdaux_alloc_ctrl (4 ports, 3 channels); watchdog steps run only when
// BWDAUX_TIMEOUT_EN is defined.
module tb_bwdaux_alloc_ctrl;

`ifdef BWDAUX_TIMEOUT_EN
  localparam int unsigned Tmo = 8;
`else
  localparam int unsigned Tmo = 256;
`endif

  logic        clk;
  logic        rst;
  logic [11:0] req;
  logic [3:0]  fv;
  logic [3:0]  ft;
  logic [2:0]  st;
  logic [11:0] alloc;
  logic [2:0]  aux;
  logic [2:0]  terr;

  int checks = 0;
  int errors = 0;

  bwdaux_alloc_ctrl #(
    .SwitchOutputs (4),
    .NumAux        (3),
    .TimeoutCycles (Tmo)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_i         (req),
    .flit_valid_i  (fv),
    .flit_tail_i   (ft),
    .aux_stall_i   (st),
    .alloc_out_o   (alloc),
    .aux_out_c_o   (aux),
    .timeout_err_o (terr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    req = 12'hFFF;
    fv  = 4'h0;
    ft  = 4'h0;
    st  = 3'b000;
    tick();
    tick();
    chk("rst_alloc", 32'(alloc), 32'h000);
    chk("rst_aux", 32'(aux), 32'h0);
    chk("rst_terr", 32'(terr), 32'h0);

    // First edge after reset grants port 0 on every channel.
    rst = 1'b0;
    tick();
    chk("first_grant", 32'(alloc), 32'h111);
    req = 12'h000;
    fv  = 4'b0001;
    ft  = 4'b0001;
    tick();
    chk("single_flit_rel", 32'(alloc), 32'h000);
    chk("single_flit_aux", 32'(aux), 32'h7);
    fv = 4'h0;
    ft = 4'h0;
    tick();
    chk("single_flit_aux_off", 32'(aux), 32'h0);

    // Channel 0: ports 1 and 3 alternate, 3-flit packets. Pointer is 1 here.
    req = 12'h00A;
    tick();
    chk("rr_grant_p1", 32'(alloc), 32'h002);
    fv = 4'b1010;
    tick();
    chk("p1_f1_aux", 32'(aux), 32'h1);
    tick();
    chk("p1_f2_alloc", 32'(alloc), 32'h002);
    ft = 4'b1010;
    tick();
    chk("p1_tail_rel", 32'(alloc), 32'h000);
    chk("p1_tail_aux", 32'(aux), 32'h1);
    ft = 4'b0000;
    tick();
    chk("rr_grant_p3", 32'(alloc), 32'h008);
    chk("idle_gap_aux", 32'(aux), 32'h0);
    tick();
    chk("p3_f1_aux", 32'(aux), 32'h1);
    tick();
    ft = 4'b1010;
    tick();
    chk("p3_tail_rel", 32'(alloc), 32'h000);
    req = 12'h000;
    fv  = 4'h0;
    ft  = 4'h0;
    tick();
    chk("no_req_alloc", 32'(alloc), 32'h000);
    chk("no_req_aux", 32'(aux), 32'h0);

    // Channel 1: port 2, tail held under stall for 4 cycles.
    req = 12'h040;
    tick();
    chk("ch1_grant_p2", 32'(alloc), 32'h040);
    fv = 4'b0100;
    ft = 4'b0100;
    st = 3'b010;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_hold_alloc", 32'(alloc), 32'h040);
      chk("stall_aux", 32'(aux), 32'h0);
    end
    st = 3'b000;
    tick();
    chk("unstall_rel", 32'(alloc), 32'h000);
    chk("unstall_aux", 32'(aux), 32'h2);
    req = 12'h000;
    fv  = 4'h0;
    ft  = 4'h0;
    tick();
    chk("unstall_aux_off", 32'(aux), 32'h0);

    // Channel 2: port 1 granted (pointer 1), reset after 2 flits.
    req = 12'h200;
    tick();
    chk("ch2_grant_p1", 32'(alloc), 32'h200);
    fv = 4'b0010;
    tick();
    tick();
    chk("ch2_mid_aux", 32'(aux), 32'h4);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_alloc", 32'(alloc), 32'h000);
    chk("async_rst_aux", 32'(aux), 32'h0);
    fv  = 4'h0;
    req = 12'h300;
    tick();
    rst = 1'b0;
    // Pointer is back at 0, so port 0 wins over port 1.
    tick();
    chk("post_rst_ptr0", 32'(alloc), 32'h100);
    fv = 4'b0001;
    ft = 4'b0001;
    req = 12'h000;
    tick();
    chk("post_rst_rel", 32'(alloc), 32'h000);
    chk("post_rst_aux", 32'(aux), 32'h4);
    fv = 4'h0;
    ft = 4'h0;
    tick();

`ifdef BWDAUX_TIMEOUT_EN
    // Channel 0 (pointer 0): ports 1 and 2 request; port 1 never sends.
    req = 12'h006;
    tick();
    chk("wd_grant_p1", 32'(alloc), 32'h002);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("wd_hold", 32'(alloc), 32'h002);
      chk("wd_no_err", 32'(terr), 32'h0);
    end
    tick();
    chk("wd_release", 32'(alloc), 32'h000);
    chk("wd_err_pulse", 32'(terr), 32'h1);
    tick();
    chk("wd_err_clear", 32'(terr), 32'h0);
    chk("wd_next_p2", 32'(alloc), 32'h004);
`else
    chk("terr_tied", 32'(terr), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
